// File: rtl/glogic16_arb.sv
`default_nettype none
// ============================================================================
// Module   : glogic16_arb
// Brief    : Two-requester arbiter and sequencer for the shared 16-bit logic
//            unit (NOT / AND / OR / XOR). The arbiter grants one requester,
//            registers its operands, computes the result in a single shared
//            unit, and holds the result until the consumer accepts it.
//            Only one operation is in flight at a time.
// Config   : GLOGIC16_ARB_FIXPRI_EN
//            Defined   -> fixed priority. Requester 0 wins every tie and no
//                         priority register is built.
//            Undefined -> round-robin arbitration (default).
// Revision : 1.0  initial release
// ============================================================================
module glogic16_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v0,
    input  logic        v1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        rdy0,
    output logic        rdy1,
    output logic        out_valid,
    output logic [15:0] out_y,
    output logic        out_id,
    input  logic        out_ready
);

    // Sequencer states.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Opcodes of the shared logic unit.
    localparam logic [1:0] c_OP_NOT = 2'b00;
    localparam logic [1:0] c_OP_AND = 2'b01;
    localparam logic [1:0] c_OP_OR  = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    // Operands captured at grant time. They feed the shared unit during EXEC.
    logic [1:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_id;

    // Result registers. They are visible on the output ports.
    logic        r_out_valid;
    logic [15:0] r_out_y;
    logic        r_out_id;

    logic        w_any_req;
    logic        w_grant;
    logic        w_accept;
    logic        w_handshake;
    logic        w_prio;
    logic [15:0] w_unit_y;

    // A request is accepted only in IDLE. The result is retired in DONE
    // when the consumer is ready.
    assign w_any_req   = v0 | v1;
    assign w_accept    = (r_state == c_ST_IDLE) & w_any_req;
    assign w_handshake = (r_state == c_ST_DONE) & out_ready;

    // If only one requester is valid, it gets the grant. On a tie, the
    // priority pointer selects the winner.
    assign w_grant = (v0 & v1) ? w_prio : v1;

`ifdef GLOGIC16_ARB_FIXPRI_EN
    // Fixed priority: requester 0 always wins a tie.
    assign w_prio = 1'b0;
`else
    logic r_prio;

    // Round-robin pointer. After each retired result it points away from
    // the requester that was just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_handshake) begin
            r_prio <= ~r_out_id;
        end
    end

    assign w_prio = r_prio;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. EXEC always lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Request-side handshake. At most one rdy is high, and only in IDLE.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (r_state == c_ST_IDLE && w_any_req) begin
            rdy0 = ~w_grant;
            rdy1 =  w_grant;
        end
    end

    // Capture the granted requester's opcode, operands and id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 2'b00;
            r_a  <= 16'h0000;
            r_b  <= 16'h0000;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_op <= w_grant ? op1 : op0;
            r_a  <= w_grant ? a1  : a0;
            r_b  <= w_grant ? b1  : b0;
            r_id <= w_grant;
        end
    end

    // Shared logic unit. The NOT path uses the inverter datapath. The
    // other operations are plain bitwise functions. No carry, no extension.
    always_comb begin
        w_unit_y = 16'h0000;
        case (r_op)
            c_OP_NOT: w_unit_y = ~r_a;
            c_OP_AND: w_unit_y = r_a & r_b;
            c_OP_OR:  w_unit_y = r_a | r_b;
            default:  w_unit_y = r_a ^ r_b;
        endcase
    end

    // Result registers. They load at the end of EXEC and hold through DONE.
    // On reset, out_valid drops asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= 16'h0000;
            r_out_id    <= 1'b0;
        end else if (r_state == c_ST_EXEC) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_unit_y;
            r_out_id    <= r_id;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_glogic16_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_glogic16_arb
// Brief    : Self-checking bench for glogic16_arb. A transaction-level
//            reference model tracks the request queue, the busy window and
//            the tie-break pointer, and predicts rdy and result every cycle.
//            Honours GLOGIC16_ARB_FIXPRI_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_glogic16_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    logic [1:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        rdy0, rdy1;
    logic        out_valid;
    logic [15:0] out_y;
    logic        out_id;
    logic        out_ready;

    int n_total = 0;
    int n_bad   = 0;

    glogic16_arb u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .v0        (v0),
        .v1        (v1),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .rdy0      (rdy0),
        .rdy1      (rdy1),
        .out_valid (out_valid),
        .out_y     (out_y),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Reference model state.
    bit          m_busy;
    int          m_acc;
    logic [15:0] m_y;
    bit          m_id;
    bit          m_prio;
    bit          pend [2];
    logic [1:0]  pop  [2];
    logic [15:0] pa   [2];
    logic [15:0] pb   [2];

    initial begin
        bit gv, g, pe, ev;

        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
        a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
        out_ready = 1'b0;
        m_busy = 0; m_acc = 0; m_y = 16'h0; m_id = 0; m_prio = 0;
        for (int w = 0; w < 2; w++) begin
            pend[w] = 0; pop[w] = 2'b00; pa[w] = 16'h0; pb[w] = 16'h0;
        end

        #12;
        check_val("rst_valid", 16'(out_valid), 16'h0);
        check_val("rst_y",     out_y,          16'h0);
        check_val("rst_id",    16'(out_id),    16'h0);
        check_val("rst_rdy0",  16'(rdy0),      16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 600; t++) begin
            // New requests. A requester that is still pending keeps its
            // request and data stable.
            for (int w = 0; w < 2; w++) begin
                if (!pend[w]) begin
                    if (t < 12) begin
                        if (w == 0 && t == 0) begin
                            pend[0] = 1; pop[0] = 2'b00; pa[0] = 16'h00FF; pb[0] = 16'h5555;
                        end
                        if (w == 1 && t == 1) begin
                            pend[1] = 1; pop[1] = 2'b11; pa[1] = 16'hAAAA; pb[1] = 16'h0F0F;
                        end
                    end else if (t < 36) begin
                        pend[w] = 1;
                        pop[w]  = (w == 0) ? 2'b01 : 2'b10;
                        pa[w]   = 16'hF0F0;
                        pb[w]   = 16'h3C3C;
                    end else if ($urandom_range(0, 2) != 0) begin
                        pend[w] = 1;
                        pop[w]  = 2'($urandom_range(0, 3));
                        pa[w]   = 16'($urandom);
                        pb[w]   = 16'($urandom);
                    end
                end
            end
            v0 = pend[0]; op0 = pop[0]; a0 = pa[0]; b0 = pb[0];
            v1 = pend[1]; op1 = pop[1]; a1 = pa[1]; b1 = pb[1];
            if (t < 12)      out_ready = (t <= 2) || (t >= 11);
            else if (t < 36) out_ready = 1'b1;
            else             out_ready = 1'($urandom_range(0, 1));

            // Predictions for this cycle.
`ifdef GLOGIC16_ARB_FIXPRI_EN
            pe = 0;
`else
            pe = m_prio;
`endif
            gv = !m_busy && (pend[0] || pend[1]);
            g  = (pend[0] && pend[1]) ? pe : pend[1];
            ev = m_busy && (t >= m_acc + 2);

            @(negedge clk);
            check_val("rdy0",      16'(rdy0),      16'(gv && !g));
            check_val("rdy1",      16'(rdy1),      16'(gv && g));
            check_val("out_valid", 16'(out_valid), 16'(ev));
            if (ev) begin
                check_val("out_y",  out_y,       m_y);
                check_val("out_id", 16'(out_id), 16'(m_id));
            end

            @(posedge clk);
            if (gv) begin
                m_busy = 1;
                m_acc  = t;
                m_y    = ref_op(pop[int'(g)], pa[int'(g)], pb[int'(g)]);
                m_id   = g;
                pend[int'(g)] = 0;
            end else if (ev && out_ready) begin
                m_busy = 0;
                m_prio = !m_id;
            end
            #1;
        end

        // Reset while DONE holds a result.
        v0 = 1'b0; v1 = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst2_valid", 16'(out_valid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b1; op0 = 2'b01; a0 = 16'h1234; b0 = 16'hFFFF;
        #1;
        check_val("d_rdy0", 16'(rdy0), 16'h1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("d_valid", 16'(out_valid), 16'h1);
        check_val("d_y",     out_y,          16'h1234);
        check_val("d_id",    16'(out_id),    16'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 16'(out_valid), 16'h0);
        check_val("arst_y",     out_y,          16'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b1; v1 = 1'b1;
        #1;
        check_val("post_rst_rdy0", 16'(rdy0), 16'h1);
        check_val("post_rst_rdy1", 16'(rdy1), 16'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
